uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, serialising host-supplied words onto one TX line. It sits between on-chip logic and the board's serial pin. It replaces fixed-message transmission with a valid/ready byte stream and configurable frame format. Frames are back-to-back whenever data is queued.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5..8.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, default 4: FIFO entries; power of two, ≥ 2.
- PARITY_ODD, default 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.

Ports:
- clk_50M, input, 1: the single clock.
- rst, input, 1: reset, synchronous and active-high.
- tx_data, input, DATA_BITS: word to send.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: FIFO can accept a word; equals !full.
- tx, output, 1: serial line; idles high; registered.
- busy, output, 1: a frame is in progress (any state except IDLE).
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of queued words.

## Operation
- Accept: tx_valid && tx_ready at a rising edge writes tx_data into the FIFO. tx_data is sampled only at that edge.
- tx_valid while full: tx_ready is low, the word is not written, and the FIFO contents are unchanged.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into a shift register, go to START, and drive tx=0.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each. Then go to PARITY if compiled in, otherwise to STOP.
  - PARITY: send the parity bit for one bit time.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop the head and go directly to START with no idle gap. Otherwise go to IDLE.
- Counters:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index: counts 0..DATA_BITS-1.
  - Stop counter: spans STOP_BITS bit times.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is exact.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A push while empty followed by a pop is allowed: data written at edge k is poppable at edge k+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.

## Timing
- Reset values: tx=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, FIFO empty.
- Reset mid-frame: at the next edge tx=1, the frame is aborted, and the FIFO is flushed.
- Latency: a word accepted at edge k into an empty FIFO while IDLE gives tx=0 and busy=1 from edge k+1.
- Bit boundaries: every bit boundary is exactly CLKS_PER_BIT cycles after the previous one, with no jitter.
- Frame end: busy falls on the same edge tx would begin IDLE, i.e. after the last stop-bit cycle, unless a back-to-back pop occurs.
- tx_ready rises the cycle after a pop that frees a full FIFO.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. The parity bit is the XOR of the data bits, inverted when PARITY_ODD=1. Frame width gains one bit.
- Undefined: no parity state or logic exists, PARITY_ODD is ignored, and the frame is 1+DATA_BITS+STOP_BITS bits.

## Test plan
- Basic frame: CLKS_PER_BIT=4, 8N1, push 0x55 from IDLE. tx reads 0,1,0,1,0,1,0,1,0,1 at 4-cycle bits. tx falls 1 cycle after accept. busy high for 40 cycles.
- Back-to-back: push 0x41, 0x42, 0x43 consecutively. The three frames are contiguous with no idle cycle between stop and start. fifo_count goes 1→2→... and then decrements once per pop.
- Full FIFO: FIFO_DEPTH=4, push 6 words with tx_valid held high. tx_ready drops once fifo_count=4. Words are accepted only when ready, and all accepted words are sent in order.
- Parity: with UART_TX_PARITY_EN, push 0x07, PARITY_ODD=0. The parity bit is 1. With PARITY_ODD=1 the parity bit is 0.
- Format: DATA_BITS=5, STOP_BITS=2, push 0x1F. tx shows start, 5 ones, then high for 2 bit times. Frame is 8*CLKS_PER_BIT cycles.
- Reset: assert rst in the middle of data bit 3 with 2 words queued. Next edge gives tx=1, busy=0, fifo_count=0, tx_ready=1. No further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; queued words go out as back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                         clk_50M,
   input  logic                         rst,
   input  logic [DATA_BITS-1:0]         tx_data,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   FIFO_ONE  = (AW+1)'(1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   logic par_bit;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [DATA_BITS-1:0] head, shreg;
   logic [CW-1:0]        bit_cnt;
   logic [IW-1:0]        bit_idx;
   logic                 stop_cnt;
   state_t               state;
   logic                 push, pop, fifo_empty, bit_end, frame_end;

   assign head       = mem[rd_ptr];
   assign fifo_empty = (fifo_count == '0);
   assign tx_ready   = (fifo_count != FIFO_FULL);
   assign push       = tx_valid && tx_ready;
   assign bit_end    = (bit_cnt == CNT_LAST);
   assign frame_end  = (state == S_STOP) && bit_end && (stop_cnt == STOP_LAST);
   // Popping on the last stop cycle lets the next start bit follow with no idle gap.
   assign pop        = !fifo_empty && ((state == S_IDLE) || frame_end);

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      fifo_count <= fifo_count + FIFO_ONE;
         else if (pop && !push) fifo_count <= fifo_count - FIFO_ONE;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg   <= head;
                  state   <= S_START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  par_bit <= (^head) ^ (PARITY_ODD != 0);
`endif
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  state   <= S_DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state    <= S_PARITY;
                     tx       <= par_bit;
`else
                     state    <= S_STOP;
                     tx       <= 1'b1;
                     stop_cnt <= 1'b0;
`endif
                  end else begin
                     bit_idx <= bit_idx + IDX_ONE;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  bit_cnt  <= '0;
                  state    <= S_STOP;
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (stop_cnt == STOP_LAST) begin
                     if (pop) begin
                        shreg <= head;
                        state <= S_START;
                        tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^head) ^ (PARITY_ODD != 0);
`endif
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 even, 5-data/2-stop odd) checked each cycle
// against a per-cycle expected-waveform queue model, plus hand-computed frame checks.
module tb_uart_tx_fifo;
   localparam int C     = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FB0 = 1 + 8 + P + 1;
   localparam int FB1 = 1 + 5 + P + 2;

   logic       clk_50M = 1'b0;
   logic       rst;
   logic [7:0] tx_data  [2];
   logic       tx_valid [2];
   logic       ready_o  [2];
   logic       tx_o     [2];
   logic       busy_o   [2];
   logic [2:0] cnt_o    [2];

   int  total = 0;
   int  bad   = 0;
   bit  checking = 1'b0;
   int  bcyc  [2];
   int  brise [2];
   logic prev_b [2];
   logic rtx   [200];
   logic rbusy [200];

   always #10 clk_50M = ~clk_50M;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int DB = (g == 0) ? 8 : 5;
      localparam int SB = (g == 0) ? 1 : 2;
      localparam int PO = g;

      uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB),
                     .FIFO_DEPTH(DEPTH), .PARITY_ODD(PO)) dut (
         .clk_50M   (clk_50M),
         .rst       (rst),
         .tx_data   (tx_data[g][DB-1:0]),
         .tx_valid  (tx_valid[g]),
         .tx_ready  (ready_o[g]),
         .tx        (tx_o[g]),
         .busy      (busy_o[g]),
         .fifo_count(cnt_o[g])
      );

      // Model: queue of words plus a queue of the tx level for every remaining cycle of the frame.
      int   q[$];
      logic wave[$];
      logic m_tx, m_busy, m_ready;
      int   m_cnt;

      always @(posedge clk_50M) begin
         bit   acc;
         int   w;
         logic b;
         logic par;
         if (rst) begin
            q.delete();
            wave.delete();
         end else begin
            acc = tx_valid[g] && (q.size() < DEPTH);
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && q.size() > 0) begin
               w   = q.pop_front();
               par = (PO != 0);
               repeat (C) wave.push_back(1'b0);
               for (int i = 0; i < DB; i++) begin
                  b   = ((w >> i) & 1) != 0;
                  par = par ^ b;
                  repeat (C) wave.push_back(b);
               end
               if (P != 0) repeat (C) wave.push_back(par);
               repeat (SB * C) wave.push_back(1'b1);
            end
            if (acc) q.push_back(int'(tx_data[g]) & ((1 << DB) - 1));
         end
         m_tx    = (wave.size() == 0) ? 1'b1 : wave[0];
         m_busy  = (wave.size() != 0);
         m_cnt   = q.size();
         m_ready = (q.size() < DEPTH);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_50M) begin
      if (checking) begin
         chk("tx0",   tx_o[0],    u[0].m_tx);
         chk("busy0", busy_o[0],  u[0].m_busy);
         chk("rdy0",  ready_o[0], u[0].m_ready);
         chk("cnt0",  cnt_o[0],   u[0].m_cnt);
         chk("tx1",   tx_o[1],    u[1].m_tx);
         chk("busy1", busy_o[1],  u[1].m_busy);
         chk("rdy1",  ready_o[1], u[1].m_ready);
         chk("cnt1",  cnt_o[1],   u[1].m_cnt);
      end
   end

   always @(negedge clk_50M) begin
      for (int g = 0; g < 2; g++) begin
         if (busy_o[g] === 1'b1) bcyc[g]++;
         if (busy_o[g] === 1'b1 && prev_b[g] !== 1'b1) brise[g]++;
         prev_b[g] = busy_o[g];
      end
   end

   // Sample j is taken at the falling edge following accept edge k+j.
   task automatic push_rec(input int g, input logic [7:0] d, input int n);
      @(negedge clk_50M);
      tx_valid[g] = 1'b1;
      tx_data[g]  = d;
      @(posedge clk_50M);
      for (int j = 0; j < n; j++) begin
         @(negedge clk_50M);
         if (j == 0) tx_valid[g] = 1'b0;
         rtx[j]   = tx_o[g];
         rbusy[j] = busy_o[g];
      end
   endtask

   task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      @(negedge clk_50M); tx_valid[0] = 1'b1; tx_data[0] = a;
      @(negedge clk_50M); tx_data[0] = b;
      @(negedge clk_50M); tx_data[0] = c;
      @(negedge clk_50M); tx_valid[0] = 1'b0;
   endtask

   initial begin
      logic [10:0] s55;
      logic [8:0]  s1f;
      int b0, r0, acc_n, guard, mx, rate;
      logic rdy;
`ifdef UART_TX_PARITY_EN
      s55 = 11'b10010101010;
      s1f = 9'b110111110;
`else
      s55 = 11'b01010101010;
      s1f = 9'b011111110;
`endif
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         tx_valid[g] = 1'b0; tx_data[g] = '0; bcyc[g] = 0; brise[g] = 0; prev_b[g] = 1'b0;
      end
      repeat (3) @(posedge clk_50M);
      checking = 1'b1;
      @(negedge clk_50M);
      chk("rst_tx", tx_o[0], 1); chk("rst_busy", busy_o[0], 0);
      chk("rst_rdy", ready_o[0], 1); chk("rst_cnt", cnt_o[0], 0);
      rst = 1'b0;
      repeat (3) @(negedge clk_50M);

      // Basic 8N1 frame of 0x55
      b0 = bcyc[0];
      push_rec(0, 8'h55, 60);
      chk("pre_start_tx", rtx[0], 1);
      chk("start_fall", rtx[1], 0);
      chk("start_busy", rbusy[1], 1);
      for (int i = 0; i < FB0; i++) chk("bits55", rtx[2 + 4 * i], s55[i]);
      chk("busy_len55", bcyc[0] - b0, FB0 * C);

      // Back-to-back frames stay contiguous
      b0 = bcyc[0]; r0 = brise[0];
      push3(8'h41, 8'h42, 8'h43);
      repeat (140) @(negedge clk_50M);
      chk("b2b_busy_len", bcyc[0] - b0, 3 * FB0 * C);
      chk("b2b_one_burst", brise[0] - r0, 1);

      // Full FIFO with tx_valid held high
      acc_n = 0; guard = 0; mx = 0;
      while (acc_n < 6 && guard < 400) begin
         @(negedge clk_50M);
         if (cnt_o[0] > mx) mx = cnt_o[0];
         tx_valid[0] = 1'b1;
         tx_data[0]  = 8'($urandom);
         rdy = ready_o[0];
         @(posedge clk_50M);
         if (rdy) acc_n++;
         guard++;
      end
      @(negedge clk_50M);
      tx_valid[0] = 1'b0;
      chk("full_accepted", acc_n, 6);
      chk("full_max_cnt", mx, 4);
      repeat (300) @(negedge clk_50M);

      // 5 data bits, 2 stop bits
      b0 = bcyc[1];
      push_rec(1, 8'h1F, 48);
      chk("fmt_start", rtx[1], 0);
      for (int i = 0; i < FB1; i++) chk("bits1f", rtx[2 + 4 * i], s1f[i]);
      chk("fmt_busy_len", bcyc[1] - b0, FB1 * C);
      repeat (5) @(negedge clk_50M);

`ifdef UART_TX_PARITY_EN
      push_rec(0, 8'h07, 60);
      chk("par_even", rtx[2 + 4 * 9], 1);
      push_rec(1, 8'h07, 48);
      chk("par_odd", rtx[2 + 4 * 6], 0);
      repeat (5) @(negedge clk_50M);
`endif

      // Reset in the middle of data bit 3 with two words queued
      push3(8'hA5, 8'h3C, 8'hC3);
      repeat (16) @(negedge clk_50M);
      chk("mid_queued", cnt_o[0], 2);
      chk("mid_busy", busy_o[0], 1);
      rst = 1'b1;
      @(negedge clk_50M);
      chk("rst_mid_tx", tx_o[0], 1); chk("rst_mid_busy", busy_o[0], 0);
      chk("rst_mid_cnt", cnt_o[0], 0); chk("rst_mid_rdy", ready_o[0], 1);
      rst = 1'b0;
      b0 = bcyc[0];
      repeat (100) @(negedge clk_50M);
      chk("no_frames_after_rst", bcyc[0] - b0, 0);

      // Randomized traffic with varying load and one reset
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk_50M);
         rate = (n < 1000) ? 80 : ((n < 2000) ? 3 : 30);
         for (int g = 0; g < 2; g++) begin
            tx_valid[g] = ($urandom_range(0, 99) < rate);
            tx_data[g]  = 8'($urandom);
         end
         rst = (n == 1500);
      end
      @(negedge clk_50M);
      rst = 1'b0;
      tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
      repeat (400) @(negedge clk_50M);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
